// File: rtl/hazard_scoreboard_pkg.sv
// rtl/hazard_scoreboard_pkg.sv - shared encodings for the hazard/forwarding/scoreboard unit
package hazard_scoreboard_pkg;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_M  = 2'b10;
    localparam logic [1:0] FWD_W  = 2'b01;

endpackage

// File: rtl/hazard_scoreboard_sb_regfile_bits.sv
// rtl/hazard_scoreboard_sb_regfile_bits.sv - pending-destination bits, occupancy count, sticky error
module sb_regfile_bits
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_ADDR_W  = 5,
    parameter int MAX_PENDING = 4,
    parameter int CNT_W       = $clog2(MAX_PENDING + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       set_en,
    input  logic [REG_ADDR_W-1:0]      set_rd,
    input  logic                       clr_valid,
    input  logic [REG_ADDR_W-1:0]      clr_rd,
    output logic [2**REG_ADDR_W-1:0]   pending,
    output logic [CNT_W-1:0]           count,
    output logic                       full,
    output logic                       err
);

    localparam logic [REG_ADDR_W-1:0] X0 = '0;

    logic                     inc;
    logic                     dec;
    logic                     bad_done;
    logic [2**REG_ADDR_W-1:0] pending_nxt;

    assign inc      = set_en && (set_rd != X0);
    // x0 can never be pending, so a completion naming x0 is always a bad completion
    assign dec      = clr_valid && (clr_rd != X0) && pending[clr_rd];
    assign bad_done = clr_valid && !dec;
    assign full     = (count == CNT_W'(MAX_PENDING));

    always_comb begin
        pending_nxt = pending;
        if (dec) pending_nxt[clr_rd] = 1'b0;
        if (inc) pending_nxt[set_rd] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
            count   <= '0;
            err     <= 1'b0;
        end else begin
            pending <= pending_nxt;
            unique case ({inc, dec})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (bad_done) err <= 1'b1;
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - stall/flush/forward control with long-latency destination scoreboard
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_ADDR_W  = 5,
    parameter int MAX_PENDING = 4,
    parameter int CNT_W       = $clog2(MAX_PENDING + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] rs1_d,
    input  logic [REG_ADDR_W-1:0] rs2_d,
    input  logic                  rs1_used_d,
    input  logic                  rs2_used_d,
    input  logic                  branch_d,
    input  logic [REG_ADDR_W-1:0] rd_d,
    input  logic                  long_d,
    input  logic                  valid_d,
    input  logic                  kill_d,
    input  logic [REG_ADDR_W-1:0] rs1_e,
    input  logic [REG_ADDR_W-1:0] rs2_e,
    input  logic [REG_ADDR_W-1:0] rd_e,
    input  logic                  reg_write_e,
    input  logic [1:0]            wb_sel_e,
    input  logic [REG_ADDR_W-1:0] rd_m,
    input  logic                  reg_write_m,
    input  logic [REG_ADDR_W-1:0] rd_w,
    input  logic                  reg_write_w,
    input  logic                  lt_done_valid,
    input  logic [REG_ADDR_W-1:0] lt_done_rd,
    output logic                  stall_f,
    output logic                  stall_d,
    output logic                  flush_e,
    output logic                  fwd1_d,
    output logic                  fwd2_d,
    output logic [1:0]            fwd1_e,
    output logic [1:0]            fwd2_e,
    output logic                  sb_full,
    output logic [CNT_W-1:0]      sb_count,
    output logic                  sb_err
);

    localparam logic [REG_ADDR_W-1:0] X0 = '0;

    logic [2**REG_ADDR_W-1:0] pending;
    logic                     m_load;
    logic                     h1;
    logic                     h2;
    logic                     src1_haz;
    logic                     src2_haz;
    logic                     waw_haz;
    logic                     struct_haz;
    logic                     hazard;
    logic                     issue;

    // M has no writeback-select input of its own; track it by delaying E's select one stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_load <= 1'b0;
        else        m_load <= (wb_sel_e == WB_MEM);
    end

    assign h1 = rs1_used_d && (rs1_d != X0);
    assign h2 = rs2_used_d && (rs2_d != X0);

    assign src1_haz = h1 && (
           ((rs1_d == rd_e) && reg_write_e && ((wb_sel_e == WB_MEM) || branch_d))
        || (branch_d && (rs1_d == rd_m) && reg_write_m && m_load)
        || pending[rs1_d]);

    assign src2_haz = h2 && (
           ((rs2_d == rd_e) && reg_write_e && ((wb_sel_e == WB_MEM) || branch_d))
        || (branch_d && (rs2_d == rd_m) && reg_write_m && m_load)
        || pending[rs2_d]);

    assign waw_haz    = valid_d && (rd_d != X0) && pending[rd_d];
    assign struct_haz = valid_d && long_d && sb_full;
    assign hazard     = src1_haz || src2_haz || waw_haz || struct_haz;

    assign stall_f = rst_n && hazard;
    assign stall_d = rst_n && hazard;
    assign flush_e = rst_n && hazard;

    assign issue = valid_d && long_d && (rd_d != X0) && !hazard && !kill_d;

    assign fwd1_d = rs1_used_d && (rs1_d != X0) && (rs1_d == rd_m) && reg_write_m;
    assign fwd2_d = rs2_used_d && (rs2_d != X0) && (rs2_d == rd_m) && reg_write_m;

    always_comb begin
        fwd1_e = FWD_RF;
        if ((rs1_e != X0) && (rs1_e == rd_m) && reg_write_m)      fwd1_e = FWD_M;
        else if ((rs1_e != X0) && (rs1_e == rd_w) && reg_write_w) fwd1_e = FWD_W;
    end

    always_comb begin
        fwd2_e = FWD_RF;
        if ((rs2_e != X0) && (rs2_e == rd_m) && reg_write_m)      fwd2_e = FWD_M;
        else if ((rs2_e != X0) && (rs2_e == rd_w) && reg_write_w) fwd2_e = FWD_W;
    end

    sb_regfile_bits #(
        .REG_ADDR_W (REG_ADDR_W),
        .MAX_PENDING(MAX_PENDING),
        .CNT_W      (CNT_W)
    ) u_bits (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (issue),
        .set_rd   (rd_d),
        .clr_valid(lt_done_valid),
        .clr_rd   (lt_done_rd),
        .pending  (pending),
        .count    (sb_count),
        .full     (sb_full),
        .err      (sb_err)
    );

endmodule
